// File: rtl/ballot_ctrl.sv
// Voting-round controller for the three-input majority voter.
// A round opens on start, collects one vote per voter (any order, any
// spacing) and closes once all three have voted or the round times out.
// On close it evaluates the majority and the one-hot decode of the votes
// and pulses result_valid for a single cycle.
module ballot_ctrl #(
  parameter int TIMEOUT = 16  // max COLLECT cycles per round, 2..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       vote_valid,
  input  logic [1:0] vote_id,
  input  logic       vote_val,
  output logic       busy,
  output logic [2:0] voted,
  output logic       F,
  output logic [7:0] pattern,
  output logic       result_valid,
  output logic       timed_out,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, COLLECT, EVAL} state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic [7:0] timer_q;
  logic [2:0] voted_q;
  logic [2:0] v_q;        // bit n holds voter n's value
  logic       f_q;
  logic [7:0] pattern_q;
  logic       rv_q;
  logic       to_q;
  logic       err_q;

  logic [2:0] id_oh_d;
  logic       legal_d;
  logic       bad_d;
  logic [2:0] mask_d;
  logic [2:0] v_d;

  // Majority of the three stored votes; missing votes are already 0.
  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // One-hot 3-to-8 decode with voter 0 as the MSB of the index.
  function automatic logic [7:0] decode3(input logic [2:0] v);
    logic [2:0] idx;
    idx = {v[0], v[1], v[2]};
    return 8'b1 << idx;
  endfunction

  // Classify this cycle's vote and form the mask/value it would produce.
  always_comb begin
    id_oh_d = 3'b000;
    case (vote_id)
      2'd0:    id_oh_d = 3'b001;
      2'd1:    id_oh_d = 3'b010;
      2'd2:    id_oh_d = 3'b100;
      default: id_oh_d = 3'b000;  // id 3 is never a legal voter
    endcase
    legal_d = vote_valid && (id_oh_d != 3'b000) && ((id_oh_d & voted_q) == 3'b000);
    bad_d   = vote_valid && !legal_d;
    mask_d  = voted_q | (legal_d ? id_oh_d : 3'b000);
    v_d     = legal_d ? ((v_q & ~id_oh_d) | (vote_val ? id_oh_d : 3'b000)) : v_q;
  end

  // Round FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= 8'd0;
      voted_q   <= 3'b000;
      v_q       <= 3'b000;
      f_q       <= 1'b0;
      pattern_q <= 8'd0;
      rv_q      <= 1'b0;
      to_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= COLLECT;
            timer_q <= 8'd0;
            voted_q <= 3'b000;
            v_q     <= 3'b000;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
          end
        end
        COLLECT: begin
          timer_q <= timer_q + 8'd1;
          voted_q <= mask_d;
          v_q     <= v_d;
          if (bad_d) err_q <= 1'b1;
          // A vote that completes the mask wins over the timeout.
          if (mask_d == 3'b111) begin
            state_q <= EVAL;
          end else if (timer_q == TLAST) begin
            state_q <= EVAL;
            to_q    <= 1'b1;
          end
        end
        EVAL: begin
          f_q       <= majority3(v_q);
          pattern_q <= decode3(v_q);
          rv_q      <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign voted        = voted_q;
  assign F            = f_q;
  assign pattern      = pattern_q;
  assign result_valid = rv_q;
  assign timed_out    = to_q;
  assign err          = err_q;

endmodule
